// File: rtl/button_press_encoder.sv
// rtl/button_press_encoder.sv - synchronise, debounce and encode the four game buttons
module button_press_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] buttonIn,
    output logic [1:0] codeOut,
    output logic       codeValid,
    output logic       buttonHeld,
    output logic       multiPress
);

    // Counter value at which a persistent difference is accepted as the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        MULTI   = 2'd2
    } state_t;

    logic [3:0]       sync_meta;
    logic [3:0]       sync;
    logic [3:0]       stable;
    logic [3:0]       stable_d;
    logic [3:0]       rise;
    logic [CNT_W-1:0] cnt [4];
    logic [2:0]       stable_count;

    state_t     state;
    state_t     state_next;
    logic [1:0] code_next;
    logic       valid_next;
    logic       multi_next;

    // Number of buttons currently accepted as pressed.
    function automatic logic [2:0] count_ones(input logic [3:0] v);
        count_ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Colour code of a one-hot button vector (bit index -> code).
    function automatic logic [1:0] encode(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                idx = 2'(i);
            end
        end
        encode = idx;
    endfunction

    // Two-flop synchroniser; the only place the raw buttons are sampled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 4'b0000;
            sync      <= 4'b0000;
        end else begin
            sync_meta <= buttonIn;
            sync      <= sync_meta;
        end
    end

    // Per-button debounce: a level change is accepted only after it has
    // persisted for DEBOUNCE_CYCLES consecutive cycles; any return to the
    // accepted level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Previous accepted levels, for press edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_d <= 4'b0000;
        end else begin
            stable_d <= stable;
        end
    end

    assign rise         = stable & ~stable_d;
    assign stable_count = count_ones(stable);

    // Press classification: a lone accepted press yields a code, a
    // simultaneous accept of several buttons yields a multi-press strobe,
    // and nothing more happens until every button is released.
    always_comb begin
        state_next = state;
        code_next  = codeOut;
        valid_next = 1'b0;
        multi_next = 1'b0;
        case (state)
            IDLE: begin
                if (count_ones(rise) == 3'd1 && stable_count == 3'd1) begin
                    code_next  = encode(rise);
                    valid_next = 1'b1;
                    state_next = PRESSED;
                end else if (stable_count >= 3'd2) begin
                    multi_next = 1'b1;
                    state_next = MULTI;
                end
            end
            PRESSED: begin
                if (stable == 4'b0000) begin
                    state_next = IDLE;
                end
            end
            MULTI: begin
                if (stable == 4'b0000) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; the code is kept until the next accepted press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            codeOut    <= 2'b00;
            codeValid  <= 1'b0;
            multiPress <= 1'b0;
        end else begin
            state      <= state_next;
            codeOut    <= code_next;
            codeValid  <= valid_next;
            multiPress <= multi_next;
        end
    end

    assign buttonHeld = (state != IDLE);

endmodule

// File: tb/tb_button_press_encoder.sv
// tb/tb_button_press_encoder.sv - randomized and directed self-check of button_press_encoder
module tb_button_press_encoder;

    localparam int D = 16;

    logic       clock;
    logic       reset;
    logic [3:0] buttonIn;
    logic [1:0] codeOut;
    logic       codeValid;
    logic       buttonHeld;
    logic       multiPress;

    button_press_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
        .clock      (clock),
        .reset      (reset),
        .buttonIn   (buttonIn),
        .codeOut    (codeOut),
        .codeValid  (codeValid),
        .buttonHeld (buttonHeld),
        .multiPress (multiPress)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: raw samples history, accepted levels and press status.
    logic [3:0] hist[$];
    logic [3:0] m_st;
    logic [3:0] m_st_d;
    int         m_mode;      // 0 nothing held, 1 single press held, 2 multi press held
    logic [1:0] m_code;
    logic       m_valid;
    logic       m_multi;

    int cyc;
    int n_valid;
    int n_multi;
    int first_valid;
    int first_release;

    task automatic model_reset();
        hist.delete();
        for (int k = 0; k < D + 2; k++) hist.push_back(4'b0000);
        m_st    = 4'b0000;
        m_st_d  = 4'b0000;
        m_mode  = 0;
        m_code  = 2'b00;
        m_valid = 1'b0;
        m_multi = 1'b0;
    endtask

    // One clock edge. A button's accepted level flips once the samples that
    // reached the synchroniser output over the last D cycles all disagree with it.
    task automatic model_edge(input logic [3:0] b);
        logic [3:0] rise;
        logic       flip;
        rise    = m_st & ~m_st_d;
        m_valid = 1'b0;
        m_multi = 1'b0;
        if (m_mode == 0) begin
            if ($countones(rise) == 1 && $countones(m_st) == 1) begin
                for (int i = 0; i < 4; i++) if (rise[i]) m_code = 2'(i);
                m_valid = 1'b1;
                m_mode  = 1;
            end else if ($countones(m_st) >= 2) begin
                m_multi = 1'b1;
                m_mode  = 2;
            end
        end else if (m_st == 4'b0000) begin
            m_mode = 0;
        end
        m_st_d = m_st;
        hist.push_front(b);
        void'(hist.pop_back());
        for (int i = 0; i < 4; i++) begin
            flip = 1'b1;
            for (int k = 2; k < D + 2; k++) begin
                if (hist[k][i] == m_st[i]) flip = 1'b0;
            end
            if (flip) m_st[i] = ~m_st[i];
        end
    endtask

    task automatic step(input logic [3:0] b, input logic r);
        @(negedge clock);
        buttonIn = b;
        reset    = r;
        if (r) begin
            #1;
            model_reset();
            check("rst_codeOut", 32'(codeOut), 32'd0);
            check("rst_codeValid", 32'(codeValid), 32'd0);
            check("rst_buttonHeld", 32'(buttonHeld), 32'd0);
            check("rst_multiPress", 32'(multiPress), 32'd0);
        end
        @(posedge clock);
        if (!r) model_edge(b);
        #1;
        cyc++;
        check("codeOut", 32'(codeOut), 32'(m_code));
        check("codeValid", 32'(codeValid), 32'(m_valid));
        check("buttonHeld", 32'(buttonHeld), 32'(m_mode != 0));
        check("multiPress", 32'(multiPress), 32'(m_multi));
        if (codeValid) begin
            n_valid++;
            if (first_valid < 0) first_valid = cyc;
        end
        if (multiPress) n_multi++;
        if (!buttonHeld && first_release < 0) first_release = cyc;
    endtask

    task automatic clear_counts();
        cyc           = 0;
        n_valid       = 0;
        n_multi       = 0;
        first_valid   = -1;
        first_release = -1;
    endtask

    task automatic hold(input logic [3:0] b, input int n);
        for (int k = 0; k < n; k++) step(b, 1'b0);
    endtask

    initial begin
        logic [3:0] b;
        int         kind;
        int         len;

        buttonIn = 4'b0000;
        reset    = 1'b1;
        model_reset();
        clear_counts();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);

        // Single GREEN press: latency, code, held, then release latency.
        clear_counts();
        hold(4'b0010, 30);
        check("t1_latency", 32'(first_valid), 32'd19);
        check("t1_nvalid", 32'(n_valid), 32'd1);
        check("t1_code", 32'(codeOut), 32'd1);
        check("t1_held", 32'(buttonHeld), 32'd1);
        clear_counts();
        hold(4'b0000, 30);
        check("t1_release", 32'(first_release), 32'd19);
        check("t1_code_kept", 32'(codeOut), 32'd1);

        // Bouncing BLUE then steady.
        clear_counts();
        for (int k = 0; k < 10; k++) step((k % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
        check("t2_no_early", 32'(n_valid), 32'd0);
        clear_counts();
        hold(4'b0100, 30);
        check("t2_latency", 32'(first_valid), 32'd19);
        check("t2_nvalid", 32'(n_valid), 32'd1);
        check("t2_code", 32'(codeOut), 32'd2);
        hold(4'b0000, 25);

        // RED+YELLOW together.
        clear_counts();
        hold(4'b1001, 30);
        check("t3_nmulti", 32'(n_multi), 32'd1);
        check("t3_nvalid", 32'(n_valid), 32'd0);
        check("t3_code_kept", 32'(codeOut), 32'd2);
        hold(4'b1000, 25);
        check("t3_held_partial", 32'(buttonHeld), 32'd1);
        hold(4'b0000, 25);
        check("t3_held_released", 32'(buttonHeld), 32'd0);

        // RED held, YELLOW added while pressed, then YELLOW alone.
        clear_counts();
        hold(4'b0001, 25);
        hold(4'b1001, 25);
        check("t4_nvalid", 32'(n_valid), 32'd1);
        check("t4_nmulti", 32'(n_multi), 32'd0);
        check("t4_code", 32'(codeOut), 32'd0);
        hold(4'b0000, 25);
        clear_counts();
        hold(4'b1000, 25);
        check("t4_second_nvalid", 32'(n_valid), 32'd1);
        check("t4_second_code", 32'(codeOut), 32'd3);
        hold(4'b0000, 25);

        // Three-cycle glitch from idle.
        clear_counts();
        hold(4'b0010, 3);
        hold(4'b0000, 25);
        check("t5_nvalid", 32'(n_valid), 32'd0);
        check("t5_nmulti", 32'(n_multi), 32'd0);
        check("t5_held", 32'(first_release), 32'd1);
        check("t5_stable", 32'(dut.stable), 32'd0);

        // Reset in the middle of a debounce count, button kept held.
        hold(4'b0100, 10);
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        clear_counts();
        hold(4'b0100, 25);
        check("t6_latency", 32'(first_valid), 32'd19);
        check("t6_code", 32'(codeOut), 32'd2);
        hold(4'b0000, 25);

        // Randomized segments against the model.
        for (int s = 0; s < 120; s++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 3) begin
                b = 4'b0001 << $urandom_range(0, 3);
                hold(b, int'($urandom_range(10, 40)));
            end else if (kind <= 5) begin
                hold(4'b0000, int'($urandom_range(5, 30)));
            end else if (kind == 6) begin
                b = 4'($urandom);
                hold(b, int'($urandom_range(1, 35)));
            end else if (kind == 7) begin
                b = 4'($urandom);
                len = int'($urandom_range(1, 4));
                for (int k = 0; k < len; k++) step(b, 1'b0);
                b = 4'($urandom);
                hold(b, int'($urandom_range(1, 6)));
            end else if (kind == 8) begin
                b = 4'($urandom);
                for (int k = 0; k < 12; k++) step(($urandom_range(0, 1) == 1) ? b : 4'b0000, 1'b0);
            end else begin
                b = 4'($urandom);
                len = int'($urandom_range(1, 2));
                for (int k = 0; k < len; k++) step(b, 1'b1);
            end
        end
        hold(4'b0000, 25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
